// File: rtl/pool_window_packer_pkg.sv
// Shared NPU max-pool definitions: window buffer states and the slot <-> bit-range mapping
// that both the packer and the reduction tree use.
package pool_window_packer_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  // Slot i occupies [slot_msb(i) : slot_lsb(i)]; slot 0 is the first element of a window.
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
    return slot * width;
  endfunction

  function automatic int unsigned slot_msb(input int unsigned slot, input int unsigned width);
    return (slot + 1) * width - 1;
  endfunction

endpackage

// File: rtl/pool_window_buf.sv
// One window buffer: slot registers, fill counter, close/last flag and EMPTY/FILLING/FULL state.
// state | meaning: EMPTY = all slots PAD | FILLING = partial window | FULL = window closed, awaiting drain
module pool_window_buf
  import pool_window_packer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_DATA   = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int                    CNT_W      = $clog2(NUM_DATA) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wr_en_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic                           wr_last_i,
  input  logic                           rd_en_i,
  output logic                           full_o,
  output logic                           close_o,
  output logic [DATA_WIDTH*NUM_DATA-1:0] data_o,
  output logic [CNT_W-1:0]               count_o,
  output logic                           last_o
);

  buf_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          last_q, last_d;
  logic [DATA_WIDTH*NUM_DATA-1:0] data_q, data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BUF_EMPTY;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= {NUM_DATA{PAD_VALUE}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // A full-length window that also carries in_last closes once, with last set.
  assign close_o = wr_en_i && (wr_last_i || (cnt_q == CNT_W'(NUM_DATA - 1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    if (rd_en_i) begin
      state_d = BUF_EMPTY;
      cnt_d   = '0;
      last_d  = 1'b0;
      data_d  = {NUM_DATA{PAD_VALUE}};
    end else if (wr_en_i) begin
      for (int i = 0; i < NUM_DATA; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          data_d[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = wr_data_i;
        end
      end
      cnt_d   = cnt_q + 1'b1;
      last_d  = wr_last_i;
      state_d = close_o ? BUF_FULL : BUF_FILLING;
    end
  end

  always_comb begin
    full_o  = (state_q == BUF_FULL);
    data_o  = data_q;
    count_o = cnt_q;
    last_o  = last_q;
  end

endmodule

// File: rtl/pool_window_packer.sv
// Serial-to-window packer for the max-pool tree: ping-pong pair of window buffers,
// write pointer follows window closes, read pointer follows output accepts.
module pool_window_packer
  import pool_window_packer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_DATA   = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int                    CNT_W      = $clog2(NUM_DATA) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [DATA_WIDTH-1:0]          in_data_i,
  input  logic                           in_last_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DATA_WIDTH*NUM_DATA-1:0] out_data_set_o,
  output logic [CNT_W-1:0]               out_count_o,
  output logic                           out_last_o
);

  logic                           wp_q, wp_d;
  logic                           rp_q, rp_d;
  logic [1:0]                     wr_en, rd_en, full, close;
  logic [1:0]                     buf_last;
  logic [DATA_WIDTH*NUM_DATA-1:0] buf_data [2];
  logic [CNT_W-1:0]               buf_count [2];
  logic                           in_acc, out_acc;

  // Ready/valid are pure decodes of registered buffer state: no out_ready -> in_ready path.
  assign in_ready_o  = ~full[wp_q];
  assign out_valid_o = full[rp_q];
  assign in_acc      = in_valid_i && in_ready_o;
  assign out_acc     = out_valid_o && out_ready_i;

  always_comb begin
    wr_en        = '0;
    rd_en        = '0;
    wr_en[wp_q]  = in_acc;
    rd_en[rp_q]  = out_acc;
    wp_d         = wp_q ^ (|close);
    rp_d         = rp_q ^ out_acc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= 1'b0;
      rp_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    pool_window_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_DATA   (NUM_DATA),
      .PAD_VALUE  (PAD_VALUE),
      .CNT_W      (CNT_W)
    ) u_buf (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_en[b]),
      .wr_data_i (in_data_i),
      .wr_last_i (in_last_i),
      .rd_en_i   (rd_en[b]),
      .full_o    (full[b]),
      .close_o   (close[b]),
      .data_o    (buf_data[b]),
      .count_o   (buf_count[b]),
      .last_o    (buf_last[b])
    );
  end

  assign out_data_set_o = buf_data[rp_q];
  assign out_count_o    = buf_count[rp_q];
  assign out_last_o     = buf_last[rp_q];

endmodule
